// File: rtl/freq_cnt_ctrl.sv
// Gated-count frequency meter with automatic 1 s / 0.1 s / 0.01 s gate ranging.
// Counts synchronised rising edges of sig_in in BCD and publishes 8 digits for the display.
module freq_cnt_ctrl #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int OVF_DIGITS = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sig_in,
  input  logic       hold,
  output logic [3:0] data1,
  output logic [3:0] data2,
  output logic [3:0] data3,
  output logic [3:0] data4,
  output logic [3:0] data5,
  output logic [3:0] data6,
  output logic [3:0] data7,
  output logic [3:0] data8,
  output logic [2:0] sel,
  output logic [2:0] dp,
  output logic       over,
  output logic       meas_valid
);

  localparam int GATE_W = $clog2(CLK_HZ) + 1;
  localparam logic [GATE_W-1:0] GATE0_M1 = GATE_W'(CLK_HZ - 1);
  localparam logic [GATE_W-1:0] GATE1_M1 = GATE_W'(CLK_HZ / 10 - 1);
  localparam logic [GATE_W-1:0] GATE2_M1 = GATE_W'(CLK_HZ / 100 - 1);

  typedef enum logic [1:0] {
    ST_ARM  = 2'd0,
    ST_GATE = 2'd1,
    ST_EVAL = 2'd2
  } state_t;

  state_t            state_reg;
  logic [1:0]        range_reg;
  logic [GATE_W-1:0] gate_cnt_reg;
  logic [GATE_W-1:0] gate_load;

  logic sync1_reg;
  logic sync2_reg;
  logic sync3_reg;
  logic edge_reg;

  // Digit 0 is the least significant BCD digit.
  logic [7:0][3:0] cnt_reg;
  logic [7:0][3:0] cnt_next;
  logic [8:0]      carry;
  logic [7:0]      ovf_nz;
  logic [7:0]      udr_nz;
  logic            saturated;
  logic            is_ovf;
  logic            is_udr;

  logic [7:0][3:0] data_reg;
  logic [2:0]      sel_reg;
  logic [2:0]      sel_next;
  logic            over_reg;
  logic            meas_valid_reg;

  assign carry[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi = gi + 1) begin : g_digit
      assign carry[gi+1]  = carry[gi] & (cnt_reg[gi] == 4'd9);
      assign cnt_next[gi] = carry[gi] ? ((cnt_reg[gi] == 4'd9) ? 4'd0 : cnt_reg[gi] + 4'd1)
                                      : cnt_reg[gi];
      if (gi >= OVF_DIGITS) begin : g_ovf
        assign ovf_nz[gi] = |cnt_reg[gi];
      end else begin : g_no_ovf
        assign ovf_nz[gi] = 1'b0;
      end
      if (gi >= OVF_DIGITS - 1) begin : g_udr
        assign udr_nz[gi] = |cnt_reg[gi];
      end else begin : g_no_udr
        assign udr_nz[gi] = 1'b0;
      end
    end
  endgenerate

  // A carry out of the top digit means the counter already reads 99999999.
  assign saturated = carry[8];
  assign is_ovf    = |ovf_nz;
  assign is_udr    = ~|udr_nz;

  always_comb begin
    gate_load = GATE2_M1;
    sel_next  = 3'b001;
    case (range_reg)
      2'd0: begin
        gate_load = GATE0_M1;
        sel_next  = 3'b100;
      end
      2'd1: begin
        gate_load = GATE1_M1;
        sel_next  = 3'b010;
      end
      default: begin
        gate_load = GATE2_M1;
        sel_next  = 3'b001;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg      <= 1'b0;
      sync2_reg      <= 1'b0;
      sync3_reg      <= 1'b0;
      edge_reg       <= 1'b0;
      state_reg      <= ST_ARM;
      range_reg      <= 2'd0;
      gate_cnt_reg   <= '0;
      cnt_reg        <= '0;
      data_reg       <= '0;
      sel_reg        <= 3'b100;
      over_reg       <= 1'b0;
      meas_valid_reg <= 1'b0;
    end else begin
      sync1_reg      <= sig_in;
      sync2_reg      <= sync1_reg;
      sync3_reg      <= sync2_reg;
      edge_reg       <= sync2_reg & ~sync3_reg;
      meas_valid_reg <= 1'b0;
      case (state_reg)
        ST_ARM: begin
          cnt_reg      <= '0;
          gate_cnt_reg <= gate_load;
          state_reg    <= ST_GATE;
        end
        ST_GATE: begin
          if (edge_reg && !saturated) begin
            cnt_reg <= cnt_next;
          end
          if (gate_cnt_reg == '0) begin
            state_reg <= ST_EVAL;
          end else begin
            gate_cnt_reg <= gate_cnt_reg - 1'b1;
          end
        end
        ST_EVAL: begin
          state_reg <= ST_ARM;
          if (is_ovf && range_reg != 2'd2) begin
            range_reg <= range_reg + 2'd1;
          end else if (is_udr && range_reg != 2'd0) begin
            range_reg <= range_reg - 2'd1;
          end else if (!hold) begin
            data_reg       <= cnt_reg;
            sel_reg        <= sel_next;
            over_reg       <= is_ovf;
            meas_valid_reg <= 1'b1;
          end
        end
        default: state_reg <= ST_ARM;
      endcase
    end
  end

  assign data1      = data_reg[7];
  assign data2      = data_reg[6];
  assign data3      = data_reg[5];
  assign data4      = data_reg[4];
  assign data5      = data_reg[3];
  assign data6      = data_reg[2];
  assign data7      = data_reg[1];
  assign data8      = data_reg[0];
  assign sel        = sel_reg;
  assign dp         = ~sel_reg;
  assign over       = over_reg;
  assign meas_valid = meas_valid_reg;

endmodule

// File: tb/tb_freq_cnt_ctrl.sv
// Directed bench: three instances (OVF_DIGITS 6, 3, 1) at CLK_HZ=10000 run side by side
// on one clock, checked at hand-computed cycle numbers after reset release.
module tb_freq_cnt_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;
  logic sig_a, sig_b, sig_c;
  logic hold_a, hold_b, hold_c;
  logic [7:0][3:0] da, db, dc;
  logic [2:0] sel_a, sel_b, sel_c, dp_a, dp_b, dp_c;
  logic over_a, over_b, over_c, mv_a, mv_b, mv_c;

  int per_a, per_b, per_c;
  int ph_a, ph_b, ph_c;
  int cnt_a, cnt_b, cnt_c;
  int cyc;
  int base, base_c;
  int checks, errors;

  freq_cnt_ctrl #(.CLK_HZ(10000), .OVF_DIGITS(6)) u_a (
    .clk(clk), .rst(rst_a), .sig_in(sig_a), .hold(hold_a),
    .data1(da[7]), .data2(da[6]), .data3(da[5]), .data4(da[4]),
    .data5(da[3]), .data6(da[2]), .data7(da[1]), .data8(da[0]),
    .sel(sel_a), .dp(dp_a), .over(over_a), .meas_valid(mv_a)
  );

  freq_cnt_ctrl #(.CLK_HZ(10000), .OVF_DIGITS(3)) u_b (
    .clk(clk), .rst(rst_b), .sig_in(sig_b), .hold(hold_b),
    .data1(db[7]), .data2(db[6]), .data3(db[5]), .data4(db[4]),
    .data5(db[3]), .data6(db[2]), .data7(db[1]), .data8(db[0]),
    .sel(sel_b), .dp(dp_b), .over(over_b), .meas_valid(mv_b)
  );

  freq_cnt_ctrl #(.CLK_HZ(10000), .OVF_DIGITS(1)) u_c (
    .clk(clk), .rst(rst_c), .sig_in(sig_c), .hold(hold_c),
    .data1(dc[7]), .data2(dc[6]), .data3(dc[5]), .data4(dc[4]),
    .data5(dc[3]), .data6(dc[2]), .data7(dc[1]), .data8(dc[0]),
    .sel(sel_c), .dp(dp_c), .over(over_c), .meas_valid(mv_c)
  );

  initial cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Square-wave sources: per_x cycles per period, 50 % duty, low while in reset.
  initial begin
    ph_a = 0; ph_b = 0; ph_c = 0;
    forever begin
      @(negedge clk);
      if (rst_a) begin ph_a = 0; sig_a = 1'b0; end
      else if (per_a == 0) sig_a = 1'b0;
      else begin ph_a = (ph_a + 1) % per_a; sig_a = (ph_a < per_a / 2); end
      if (rst_b) begin ph_b = 0; sig_b = 1'b0; end
      else if (per_b == 0) sig_b = 1'b0;
      else begin ph_b = (ph_b + 1) % per_b; sig_b = (ph_b < per_b / 2); end
      if (rst_c) begin ph_c = 0; sig_c = 1'b0; end
      else if (per_c == 0) sig_c = 1'b0;
      else begin ph_c = (ph_c + 1) % per_c; sig_c = (ph_c < per_c / 2); end
    end
  end

  initial begin
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    forever begin
      @(negedge clk);
      if (mv_a === 1'b1) cnt_a = cnt_a + 1;
      if (mv_b === 1'b1) cnt_b = cnt_b + 1;
      if (mv_c === 1'b1) cnt_c = cnt_c + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    hold_a = 1'b0; hold_b = 1'b0; hold_c = 1'b0;
    per_a = 4; per_b = 4; per_c = 2;
    sig_a = 1'b0; sig_b = 1'b0; sig_c = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_a", da, 32'h0);
    chk("rst_sel_a", 32'(sel_a), 32'h4);
    chk("rst_dp_a", 32'(dp_a), 32'h3);
    chk("rst_over_a", 32'(over_a), 32'h0);
    chk("rst_mv_a", 32'(mv_a), 32'h0);
    chk("rst_sel_c", 32'(sel_c), 32'h4);

    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    base = cyc;

    // A: 1 s gate, period 4 -> 2500 published at cycle 10002
    wait_to(base + 10001);
    chk("a_mv_early", 32'(mv_a), 32'h0);
    wait_to(base + 10002);
    chk("a_mv_first", 32'(mv_a), 32'h1);
    chk("a_data_first", da, 32'h0000_2500);
    chk("a_sel_first", 32'(sel_a), 32'h4);
    chk("a_dp_first", 32'(dp_a), 32'h3);
    chk("a_over_first", 32'(over_a), 32'h0);
    chk("b_mv_discard", 32'(mv_b), 32'h0);
    chk("c_mv_discard0", 32'(mv_c), 32'h0);
    wait_to(base + 10003);
    chk("a_mv_pulse", 32'(mv_a), 32'h0);
    chk("a_data_holds", da, 32'h0000_2500);
    wait_to(base + 10010);
    per_a = 8;

    // B: ranged up to 0.1 s gate -> 250 at cycle 11004
    wait_to(base + 11004);
    chk("b_mv_r1", 32'(mv_b), 32'h1);
    chk("b_data_r1", db, 32'h0000_0250);
    chk("b_sel_r1", 32'(sel_b), 32'h2);
    chk("b_dp_r1", 32'(dp_b), 32'h5);
    chk("b_over_r1", 32'(over_b), 32'h0);
    chk("c_mv_discard1", 32'(mv_c), 32'h0);
    per_b = 40;

    // C: two range steps, then 50 on the 0.01 s gate with over set
    wait_to(base + 11106);
    chk("c_mv_r2", 32'(mv_c), 32'h1);
    chk("c_data_r2", dc, 32'h0000_0050);
    chk("c_sel_r2", 32'(sel_c), 32'h1);
    chk("c_dp_r2", 32'(dp_c), 32'h6);
    chk("c_over_r2", 32'(over_c), 32'h1);

    // C: one-cycle reset mid-gate, then sig_in held low
    wait_to(base + 11150);
    chk("c_pulses_pre_rst", 32'(cnt_c), 32'd1);
    @(negedge clk);
    rst_c = 1'b1;
    per_c = 0;
    @(posedge clk);
    #1;
    chk("c_rst_sel", 32'(sel_c), 32'h4);
    chk("c_rst_data", dc, 32'h0);
    chk("c_rst_over", 32'(over_c), 32'h0);
    chk("c_rst_dp", 32'(dp_c), 32'h3);
    @(negedge clk);
    rst_c = 1'b0;
    base_c = cyc;

    // B: 25 on 0.1 s is underrange -> back to 1 s, no publish
    wait_to(base + 12006);
    chk("b_mv_down", 32'(mv_b), 32'h0);
    chk("b_pulses_mid", 32'(cnt_b), 32'd1);

    // A: hold across EVAL suppresses the publish
    wait_to(base + 20000);
    hold_a = 1'b1;
    wait_to(base + 20004);
    chk("a_mv_hold", 32'(mv_a), 32'h0);
    chk("a_data_hold", da, 32'h0000_2500);
    hold_a = 1'b0;

    wait_to(base_c + 10001);
    chk("c_mv_before_idle", 32'(mv_c), 32'h0);
    wait_to(base_c + 10002);
    chk("c_mv_idle", 32'(mv_c), 32'h1);
    chk("c_data_idle", dc, 32'h0);
    chk("c_sel_idle", 32'(sel_c), 32'h4);
    chk("c_over_idle", 32'(over_c), 32'h0);

    wait_to(base + 22008);
    chk("b_mv_r0", 32'(mv_b), 32'h1);
    chk("b_data_r0", db, 32'h0000_0250);
    chk("b_sel_r0", 32'(sel_b), 32'h4);
    chk("b_dp_r0", 32'(dp_b), 32'h3);

    wait_to(base + 30006);
    chk("a_mv_unhold", 32'(mv_a), 32'h1);
    chk("a_data_unhold", da, 32'h0000_1250);
    chk("a_sel_unhold", 32'(sel_a), 32'h4);

    wait_to(base_c + 20004);
    chk("c_mv_idle2", 32'(mv_c), 32'h1);
    chk("c_data_idle2", dc, 32'h0);
    wait_to(base_c + 20005);
    chk("c_mv_idle2_end", 32'(mv_c), 32'h0);

    wait_to(base + 31160);
    chk("a_pulses", 32'(cnt_a), 32'd2);
    chk("b_pulses", 32'(cnt_b), 32'd2);
    chk("c_pulses", 32'(cnt_c), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
